// File: rtl/aes_pkg.sv
// Shared AES definitions: round-controller state encoding, stage codes and default sizes.
// Imported by the round controller, its watchdog and the key expansion.
package aes_pkg;

    localparam int unsigned NR_DEFAULT      = 10;
    localparam int unsigned ROUND_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        StIdle,
        StKey,
        StArk,
        StSub,
        StShift,
        StMix,
        StFin
    } aes_state_e;

    // One-hot stage enables, bit order {ark, sub, shift, mix}.
    localparam logic [3:0] STAGE_NONE  = 4'b0000;
    localparam logic [3:0] STAGE_ARK   = 4'b1000;
    localparam logic [3:0] STAGE_SUB   = 4'b0100;
    localparam logic [3:0] STAGE_SHIFT = 4'b0010;
    localparam logic [3:0] STAGE_MIX   = 4'b0001;

endpackage

// File: rtl/stage_watchdog.sv
// Per-state cycle counter: cleared on every state change, flags the launch cycle
// (count zero) and expires when the count reaches TIMEOUT.
module stage_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic launch,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign launch  = (cnt_q == '0);
    assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks KEY/ARK/SUB/SHIFT/MIX per round with a
// handshake watchdog; outputs decode only from registered state and round.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR      = NR_DEFAULT,
    parameter int unsigned ROUND_W = ROUND_W_DEFAULT,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               key_ready,
    input  logic               stage_done,
    output logic               key_req,
    output logic               ark_en,
    output logic               sub_en,
    output logic               shift_en,
    output logic               mix_en,
    output logic [ROUND_W-1:0] round,
    output logic               state_sel,
    output logic               busy,
    output logic               done,
    output logic               err
);
    aes_state_e         state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [3:0]         stage;
    logic               active, launch, expired, stage_adv, last_round;

    assign active     = state_q inside {StKey, StArk, StSub, StShift, StMix};
    assign last_round = (round_q == ROUND_W'(NR));
    // The launch cycle ignores stage_done so a stale done cannot skip a stage.
    assign stage_adv  = stage_done && !launch;

    stage_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_d != state_q),
        .inc    (active),
        .launch (launch),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        if (active && expired) begin
            state_d = StIdle;
            round_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StKey;
                        round_d = '0;
                    end
                end
                StKey:   if (key_ready) state_d = StArk;
                StArk: begin
                    if (stage_adv) begin
                        if (last_round) begin
                            state_d = StFin;
                        end else begin
                            state_d = StSub;
                            round_d = round_q + 1'b1;
                        end
                    end
                end
                StSub:   if (stage_adv) state_d = StShift;
                StShift: if (stage_adv) state_d = last_round ? StKey : StMix;
                StMix:   if (stage_adv) state_d = StKey;
                StFin:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        stage = STAGE_NONE;
        unique case (state_q)
            StArk:   stage = STAGE_ARK;
            StSub:   stage = STAGE_SUB;
            StShift: stage = STAGE_SHIFT;
            StMix:   stage = STAGE_MIX;
            default: stage = STAGE_NONE;
        endcase
        {ark_en, sub_en, shift_en, mix_en} = stage;
        key_req   = (state_q == StKey);
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        err       = active && expired;
        round     = round_q;
        state_sel = (round_q != '0);
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: table-driven full runs plus hand-written
// timeout, async-reset and start-ignore sequences against behavioural responders.
module tb_aes_round_ctrl;
    localparam int unsigned NR      = 10;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned TIMEOUT = 255;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               key_ready  = 1'b0;
    logic               stage_done = 1'b0;
    logic               key_req, ark_en, sub_en, shift_en, mix_en;
    logic [ROUND_W-1:0] round;
    logic               state_sel, busy, done, err;

    aes_round_ctrl #(
        .NR     (NR),
        .ROUND_W(ROUND_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_ready (key_ready),
        .stage_done(stage_done),
        .key_req   (key_req),
        .ark_en    (ark_en),
        .sub_en    (sub_en),
        .shift_en  (shift_en),
        .mix_en    (mix_en),
        .round     (round),
        .state_sel (state_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Responder configuration: 0 ideal, 1 done stuck high, 2 done stuck low in SUB of round 2.
    int done_mode = 0;
    int kd_round  = -1;
    int kd        = 0;

    logic [3:0] stg;
    logic [3:0] stg_prev = 4'b0;
    int         key_cnt  = 0;
    assign stg = {ark_en, sub_en, shift_en, mix_en};

    always @(negedge clk) begin
        if (key_req) key_cnt++;
        else key_cnt = 0;
        key_ready = !(key_req && int'(round) == kd_round && key_cnt <= kd);
        case (done_mode)
            1:       stage_done = 1'b1;
            2:       stage_done = (stg != 4'b0) && (stg == stg_prev) && !(sub_en && round == 2);
            default: stage_done = (stg != 4'b0) && (stg == stg_prev);
        endcase
        stg_prev = stg;
    end

    function automatic logic [31:0] outs();
        return {19'b0, key_req, ark_en, sub_en, shift_en, mix_en, round,
                state_sel, busy, done, err};
    endfunction

    // Pulses start (sampled at the next edge) and follows the run to the done cycle.
    task automatic run_check(input string tag, input int exp_cycles, input int exp_keys,
                             input bit inject);
        logic [3:0] exp_code[$];
        int         exp_rnd[$];
        logic [3:0] last;
        int cyc, seg_n, len, bad_code, bad_len, multi, mix_last, keys, done_cyc;
        exp_code.push_back(4'b1000);
        exp_rnd.push_back(0);
        for (int r = 1; r <= int'(NR); r++) begin
            exp_code.push_back(4'b0100); exp_rnd.push_back(r);
            exp_code.push_back(4'b0010); exp_rnd.push_back(r);
            if (r != int'(NR)) begin
                exp_code.push_back(4'b0001); exp_rnd.push_back(r);
            end
            exp_code.push_back(4'b1000); exp_rnd.push_back(r);
        end
        last = 4'b0;
        seg_n = 0; len = 0; bad_code = 0; bad_len = 0; multi = 0;
        mix_last = 0; keys = 0; done_cyc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        chk({tag, " key_req first cycle"}, key_req, 1);
        chk({tag, " round first cycle"}, round, 0);
        chk({tag, " state_sel first cycle"}, state_sel, 0);
        while (done_cyc == 0 && cyc <= 200) begin
            if (inject && cyc == 40) start = 1'b1;
            if (inject && cyc == 41) start = 1'b0;
            if ($countones(stg) > 1) multi++;
            if (mix_en && round == NR) mix_last++;
            if (key_req) keys++;
            if (stg != last) begin
                if (last != 4'b0 && len != 2) bad_len++;
                len = 1;
                if (stg != 4'b0) begin
                    if (seg_n >= exp_code.size() || stg != exp_code[seg_n] ||
                        int'(round) != exp_rnd[seg_n]) bad_code++;
                    seg_n++;
                end
            end else if (stg != 4'b0) begin
                len++;
            end
            last = stg;
            if (done) done_cyc = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk({tag, " done cycle"}, done_cyc, exp_cycles);
        chk({tag, " stage count"}, seg_n, exp_code.size());
        chk({tag, " stage order/round errors"}, bad_code, 0);
        chk({tag, " stage length errors"}, bad_len, 0);
        chk({tag, " multiple enables"}, multi, 0);
        chk({tag, " mix at last round"}, mix_last, 0);
        chk({tag, " key_req cycles"}, keys, exp_keys);
        chk({tag, " round at done"}, round, NR);
        chk({tag, " state_sel/busy at done"}, {state_sel, busy}, 2'b11);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    kd_round;
        int    kd;
        int    exp_cycles;
        int    exp_keys;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int  n;
        logic saw_done;
        vecs[0] = '{name: "ideal",       mode: 0, kd_round: -1, kd: 0, exp_cycles: 92, exp_keys: 11};
        vecs[1] = '{name: "key_delay",   mode: 0, kd_round: 3,  kd: 5, exp_cycles: 97, exp_keys: 16};
        vecs[2] = '{name: "done_stuck1", mode: 1, kd_round: -1, kd: 0, exp_cycles: 92, exp_keys: 11};

        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", outs(), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle outputs after reset", outs(), 0);

        for (int i = 0; i < 3; i++) begin
            done_mode = vecs[i].mode;
            kd_round  = vecs[i].kd_round;
            kd        = vecs[i].kd;
            run_check(vecs[i].name, vecs[i].exp_cycles, vecs[i].exp_keys, 1'b0);
            @(posedge clk); #1;
            chk({vecs[i].name, " done/busy after done"}, {done, busy}, 2'b00);
            chk({vecs[i].name, " round holds"}, round, NR);
        end
        done_mode = 0;
        kd_round  = -1;
        kd        = 0;

        // start during busy and in the FIN cycle is ignored; start in IDLE relaunches.
        run_check("busy_start", 92, 11, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        chk("fin start ignored busy", busy, 0);
        chk("fin start ignored done", done, 0);
        run_check("back_to_back", 92, 11, 1'b0);
        @(posedge clk); #1;
        chk("back_to_back idle", busy, 0);

        // Watchdog: stage_done stuck low in SUB of round 2.
        done_mode = 2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(sub_en && round == 2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout sub entry", {sub_en, round}, {1'b1, 4'd2});
        n = 0;
        saw_done = 1'b0;
        while (!err && n < 400) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("timeout err delay", n, TIMEOUT);
        chk("timeout err in sub", {err, sub_en}, 2'b11);
        @(posedge clk); #1;
        chk("timeout err one cycle", err, 0);
        chk("timeout idle", {busy, done}, 2'b00);
        chk("timeout round cleared", round, 0);
        chk("timeout no done", saw_done, 0);
        done_mode = 0;

        // Asynchronous reset in MIX of round 5.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(mix_en && round == 5) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset mix entry", {mix_en, round}, {1'b1, 4'd5});
        #1 rst = 1'b1;
        #1;
        chk("async reset outputs", outs(), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post reset idle", outs(), 0);
        run_check("after_reset", 92, 11, 1'b0);
        @(posedge clk); #1;
        chk("after_reset idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
